sal_ref_ctrl: RTL and testbench

Auto-refresh request generator sitting directly upstream of the bank controller's refresh path. Counts tREFI intervals and accumulates owed refreshes, up to the DDR2 postpone limit. Drives the bank controller's ref_req input and consumes its ref_gnt pulse. Raises an urgent flag so the scheduler can stop issuing new row activates before the postpone budget runs out.

---
 rtl/sal_ref_ctrl_pkg.sv | 34 +++
 rtl/sal_refi_timer.sv | 42 ++++
 rtl/sal_ref_ctrl.sv | 76 +++++++
 tb/tb_sal_ref_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sal_ref_ctrl_pkg.sv
// Shared DDR timing parameters for the refresh path, plus the pending-counter
// operation decode used by the refresh request generator.
package sal_ref_ctrl_pkg;

  // Default width of the tREFI interval counter and its reload value.
  localparam int REFI_WIDTH_DEF    = 16;
  // DDR2 allows up to eight refreshes to be postponed.
  localparam int MAX_PEND_DEF      = 8;
  // Owed-refresh count at which the scheduler should stop opening rows.
  localparam int URGENT_THRESH_DEF = 6;

  // What the pending counter does in a given cycle.
  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC,
    PEND_OVF
  } pend_op_e;

  // A tick and an effective grant in the same cycle cancel out, even at the
  // postpone limit, so overflow only happens on an unmatched tick at MAX_PEND.
  function automatic pend_op_e pendOp(input logic tick, input logic gntEff,
                                      input logic atMax);
    pend_op_e op;
    op = PEND_HOLD;
    if (tick && !gntEff) begin
      op = atMax ? PEND_OVF : PEND_INC;
    end else if (!tick && gntEff) begin
      op = PEND_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/sal_refi_timer.sv
// Reloading down-counter that emits a one-cycle tick every reload_i+1
// enabled cycles. While disabled it keeps reloading, so the first interval
// after enable is always a full one.
module sal_refi_timer
  import sal_ref_ctrl_pkg::*;
#(
  parameter int W = REFI_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] reload_i,
  output logic         tick_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count and tick; a new reload value is only picked up on a reload.
  always_comb begin
    tick_o  = 1'b0;
    count_d = count_q;
    if (!en_i) begin
      count_d = reload_i;
    end else if (count_q == '0) begin
      tick_o  = 1'b1;
      count_d = reload_i;
    end else begin
      count_d = count_q - W'(1);
    end
  end

  // Interval count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sal_ref_ctrl.sv
// Auto-refresh request generator: accumulates owed refreshes from tREFI
// ticks, drains them on bank-controller grants, and flags urgency and
// postpone-limit overflow. All outputs decode registered state only.
module sal_ref_ctrl
  import sal_ref_ctrl_pkg::*;
#(
  parameter int T_REFI_WIDTH  = REFI_WIDTH_DEF,
  parameter int MAX_PEND      = MAX_PEND_DEF,
  parameter int URGENT_THRESH = URGENT_THRESH_DEF,
  localparam int PEND_W       = $clog2(MAX_PEND + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [T_REFI_WIDTH-1:0] t_refi_m1_i,
  input  logic                    ref_gnt_i,
  output logic                    ref_req_o,
  output logic                    ref_urgent_o,
  output logic [PEND_W-1:0]       pend_cnt_o,
  output logic                    ovf_err_o
);

  logic              refiTick;
  logic              gntEff;
  logic              atMax;
  pend_op_e          pendOpSel;
  logic [PEND_W-1:0] pendCnt_q;
  logic [PEND_W-1:0] pendCnt_d;
  logic              ovfErr_q;
  logic              ovfErr_d;

  sal_refi_timer #(
    .W(T_REFI_WIDTH)
  ) u_refi_timer (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .reload_i(t_refi_m1_i),
    .tick_o  (refiTick)
  );

  // Pending-count and sticky-overflow next state; grants with nothing owed are dropped.
  always_comb begin
    gntEff    = ref_gnt_i && (pendCnt_q != '0);
    atMax     = (pendCnt_q == PEND_W'(MAX_PEND));
    pendOpSel = pendOp(refiTick, gntEff, atMax);
    pendCnt_d = pendCnt_q;
    ovfErr_d  = ovfErr_q;
    case (pendOpSel)
      PEND_INC: pendCnt_d = pendCnt_q + PEND_W'(1);
      PEND_DEC: pendCnt_d = pendCnt_q - PEND_W'(1);
      PEND_OVF: ovfErr_d  = 1'b1;
      default:  pendCnt_d = pendCnt_q;
    endcase
  end

  // State registers; reset wins over any grant or tick in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendCnt_q <= '0;
      ovfErr_q  <= 1'b0;
    end else begin
      pendCnt_q <= pendCnt_d;
      ovfErr_q  <= ovfErr_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    ref_req_o    = (pendCnt_q != '0);
    ref_urgent_o = (pendCnt_q >= PEND_W'(URGENT_THRESH));
    pend_cnt_o   = pendCnt_q;
    ovf_err_o    = ovfErr_q;
  end

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Directed scoreboard bench for sal_ref_ctrl: each step drives inputs for one
// cycle, queues the expected post-edge state, then pops and compares it.
module tb_sal_ref_ctrl;

  localparam int TW   = 16;
  localparam int MAXP = 8;
  localparam int URG  = 6;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic [TW-1:0] tRefi = 16'd9;
  logic          gnt   = 1'b0;
  logic          refReq;
  logic          refUrg;
  logic [3:0]    pendCnt;
  logic          ovfErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  sal_ref_ctrl #(
    .T_REFI_WIDTH (TW),
    .MAX_PEND     (MAXP),
    .URGENT_THRESH(URG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .t_refi_m1_i (tRefi),
    .ref_gnt_i   (gnt),
    .ref_req_o   (refReq),
    .ref_urgent_o(refUrg),
    .pend_cnt_o  (pendCnt),
    .ovf_err_o   (ovfErr)
  );

  task automatic checkOne(input string tag, input string field,
                          input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard underrun observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      checkOne(e.tag, "pend_cnt",   pendCnt,         e.cnt);
      checkOne(e.tag, "ref_req",    {3'b0, refReq},  {3'b0, (e.cnt != 4'd0)});
      checkOne(e.tag, "ref_urgent", {3'b0, refUrg},  {3'b0, (e.cnt >= 4'(URG))});
      checkOne(e.tag, "ovf_err",    {3'b0, ovfErr},  {3'b0, e.ovf});
    end
  endtask

  task automatic applyStimulus(input string tag, input logic enV,
                               input logic [TW-1:0] tV, input logic gntV,
                               input logic rstV, input int expCnt,
                               input logic expOvf);
    exp_t e;
    en    = enV;
    tRefi = tV;
    gnt   = gntV;
    rst   = rstV;
    e.tag = tag;
    e.cnt = 4'(expCnt);
    e.ovf = expOvf;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int n;
    $display("[TB] start");

    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b0, 16'd9, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus("idle", 1'b0, 16'd9, 1'b0, 1'b0, 0, 1'b0);

    // tREFI = 10 cycles: ticks in enabled cycles 9, 19, 29
    for (int i = 0; i < 30; i++) applyStimulus("basic", 1'b1, 16'd9, 1'b0, 1'b0, (i + 1) / 10, 1'b0);

    applyStimulus("freeze", 1'b0, 16'd9, 1'b0, 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("drain", 1'b0, 16'd9, 1'b1, 1'b0, 2 - i, 1'b0);
    applyStimulus("gnt_at_zero", 1'b0, 16'd9, 1'b1, 1'b0, 0, 1'b0);

    // tREFI = 4 cycles, no grants: urgent at 6, saturate at 8, overflow on 9th tick
    applyStimulus("load3", 1'b0, 16'd3, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      n = (i + 1) / 4;
      applyStimulus("urgency", 1'b1, 16'd3, 1'b0, 1'b0, (n > MAXP) ? MAXP : n, (n > MAXP));
    end
    for (int i = 0; i < 8; i++) applyStimulus("drain_ovf", 1'b0, 16'd3, 1'b1, 1'b0, 7 - i, 1'b1);
    applyStimulus("clear", 1'b0, 16'd3, 1'b0, 1'b1, 0, 1'b0);

    // Fill to 8, then tick and grant together at the limit
    applyStimulus("load", 1'b0, 16'd3, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 32; i++) applyStimulus("fill", 1'b1, 16'd3, 1'b0, 1'b0, (i + 1) / 4, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("hold_max", 1'b1, 16'd3, 1'b0, 1'b0, 8, 1'b0);
    applyStimulus("tick_gnt_max", 1'b1, 16'd3, 1'b1, 1'b0, 8, 1'b0);

    // Drain to 2, then tick and grant together mid-range
    for (int i = 0; i < 6; i++) applyStimulus("drain_to2", 1'b0, 16'd3, 1'b1, 1'b0, 7 - i, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("pre_tick", 1'b1, 16'd3, 1'b0, 1'b0, 2, 1'b0);
    applyStimulus("tick_gnt_2", 1'b1, 16'd3, 1'b1, 1'b0, 2, 1'b0);

    // Refill to 5 (ticks at enabled cycles 7, 11, 15), then reset with a grant
    for (int j = 4; j < 16; j++) applyStimulus("refill", 1'b1, 16'd3, 1'b0, 1'b0, 2 + ((j >= 7) ? ((j - 7) / 4 + 1) : 0), 1'b0);
    applyStimulus("rst_gnt", 1'b1, 16'd3, 1'b1, 1'b1, 0, 1'b0);

    // Reload change 9 -> 4 mid-interval: first interval 10, then 5
    applyStimulus("reload9", 1'b0, 16'd9, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 25; i++) applyStimulus("reload_chg", 1'b1, (i < 5) ? 16'd9 : 16'd4, 1'b0, 1'b0, (i >= 9) ? ((i - 9) / 5 + 1) : 0, 1'b0);

    // tREFI = 1 cycle: increment every enabled cycle, overflow once full
    applyStimulus("load0", 1'b0, 16'd0, 1'b0, 1'b0, 4, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("refi0", 1'b1, 16'd0, 1'b0, 1'b0, 5 + i, 1'b0);
    applyStimulus("refi0_ovf", 1'b1, 16'd0, 1'b0, 1'b0, 8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
